// File: rtl/time_set_pkg.sv
// Shared types and limits for the time-set controller: FSM states and field ranges.
package time_set_pkg;

  localparam int TIME_W      = 6;
  localparam int HOURS_MAX   = 23;
  localparam int MIN_SEC_MAX = 59;

  typedef enum logic [2:0] {
    RUN,
    SET_H,
    SET_M,
    SET_S,
    COMMIT
  } state_t;

  // Field code shown to the display: 0 means no field is being edited.
  function automatic logic [1:0] mode_code(input state_t s);
    case (s)
      SET_H:   return 2'd1;
      SET_M:   return 2'd2;
      SET_S:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: the level follows raw only after DEBOUNCE_CYC consecutive
// cycles at the new value; press pulses for one cycle on an accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      press <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= raw;
        press <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: runs the 1 Hz prescaler, walks the user through editing
// hours/minutes/seconds with two buttons, and hands the result to the datapath.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [TIME_W-1:0] cur_hours,
  input  logic [TIME_W-1:0] cur_minutes,
  input  logic [TIME_W-1:0] cur_seconds,
  output logic              tick,
  output logic              load_valid,
  input  logic              load_ready,
  output logic [TIME_W-1:0] load_hours,
  output logic [TIME_W-1:0] load_minutes,
  output logic [TIME_W-1:0] load_seconds,
  output logic [1:0]        set_mode,
  output logic              blink
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2 - 1);
  localparam logic [TIME_W-1:0] H_MAX  = TIME_W'(HOURS_MAX);
  localparam logic [TIME_W-1:0] MS_MAX = TIME_W'(MIN_SEC_MAX);

  // Out-of-range captured values wrap to 0 as well as the maximum itself.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max);
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

  logic mode_level, mode_press, inc_level, inc_press;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
    .clk(clk), .reset(reset), .raw(btn_mode), .level(mode_level), .press(mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_db (
    .clk(clk), .reset(reset), .raw(btn_inc), .level(inc_level), .press(inc_press)
  );

  state_t            state, state_n;
  logic [PW-1:0]     presc, presc_n;
  logic [TIME_W-1:0] edit_h, edit_m, edit_s;
  logic [TIME_W-1:0] edit_h_n, edit_m_n, edit_s_n;
  logic              blink_n;
  logic              in_set_n;

  always_comb begin
    state_n  = state;
    edit_h_n = edit_h;
    edit_m_n = edit_m;
    edit_s_n = edit_s;
    case (state)
      RUN: if (mode_press) begin
        state_n  = SET_H;
        edit_h_n = cur_hours;
        edit_m_n = cur_minutes;
        edit_s_n = cur_seconds;
      end
      SET_H: if (mode_press) state_n = SET_M;
             else if (inc_press) edit_h_n = wrap_inc(edit_h, H_MAX);
      SET_M: if (mode_press) state_n = SET_S;
             else if (inc_press) edit_m_n = wrap_inc(edit_m, MS_MAX);
      SET_S: if (mode_press) state_n = COMMIT;
             else if (inc_press) edit_s_n = wrap_inc(edit_s, MS_MAX);
      COMMIT: if (load_valid && load_ready) state_n = RUN;
      default: state_n = RUN;
    endcase

    if (state_n != state || state == COMMIT || presc == P_LAST) presc_n = '0;
    else                                                        presc_n = presc + 1'b1;

    in_set_n = (state_n == SET_H) || (state_n == SET_M) || (state_n == SET_S);
    if (!in_set_n)                                blink_n = 1'b0;
    else if (state_n != state)                    blink_n = 1'b1;
    else if (presc == P_HALF || presc == P_LAST)  blink_n = ~blink;
    else                                          blink_n = blink;
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      presc        <= '0;
      edit_h       <= '0;
      edit_m       <= '0;
      edit_s       <= '0;
      tick         <= 1'b0;
      load_valid   <= 1'b0;
      load_hours   <= '0;
      load_minutes <= '0;
      load_seconds <= '0;
      set_mode     <= 2'd0;
      blink        <= 1'b0;
    end else begin
      state        <= state_n;
      presc        <= presc_n;
      edit_h       <= edit_h_n;
      edit_m       <= edit_m_n;
      edit_s       <= edit_s_n;
      tick         <= (state_n == RUN) && (presc_n == P_LAST);
      load_valid   <= (state_n == COMMIT);
      load_hours   <= (state_n == COMMIT) ? edit_h_n : '0;
      load_minutes <= (state_n == COMMIT) ? edit_m_n : '0;
      load_seconds <= (state_n == COMMIT) ? edit_s_n : '0;
      set_mode     <= mode_code(state_n);
      blink        <= blink_n;
    end
  end

endmodule
